sprite_row_fetcher: RTL

- Initiator for the sprite ROM read port: issues (sprite_sel, word_addr) pairs, one per cycle, and collects the returned 16-bit words.
- The ROM port has a fixed 2-cycle read latency and no stall.
- Fetches one sprite row of ROW_WORDS words per request and streams the words to the pixel/line-buffer stage over a valid/ready interface with a last flag.
- Credit-based issue into a small FIFO absorbs downstream backpressure, so no returned word is ever lost.

---
 rtl/sprite_pkg.sv | 14 +
 rtl/sprite_word_fifo.sv | 60 ++++++
 rtl/sprite_row_fetcher.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared widths, ROM timing and fetch FSM state type for the sprite row fetch path.
package sprite_pkg;
    localparam int SPRITE_SEL_W = 3;
    localparam int WORD_ADDR_W  = 10;
    localparam int WORD_W       = 16;
    localparam int ROW_W        = 6;
    localparam int ROM_LATENCY  = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } fetch_state_t;
endpackage

// File: rtl/sprite_word_fifo.sv
// Synchronous FIFO holding {last, data} words returned from the sprite ROM.
module sprite_word_fifo
    import sprite_pkg::*;
#(
    parameter int WIDTH = WORD_W + 1,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty FIFO presents zeros so stale storage never leaks onto the pixel bus.
    assign rdata = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/sprite_row_fetcher.sv
// Fetches one sprite row from the fixed-latency ROM and streams it out over valid/ready.
module sprite_row_fetcher #(
    parameter int ROM_LATENCY = sprite_pkg::ROM_LATENCY,
    parameter int ROW_WORDS   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_sprite_i,
    input  logic [5:0]  req_row_i,
    input  logic        abort_i,
    output logic [2:0]  rom_sprite_sel_o,
    output logic [9:0]  rom_word_addr_o,
    input  logic [15:0] rom_data_i,
    output logic [15:0] pix_data_o,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic        pix_last_o,
    output logic        busy_o
);
    import sprite_pkg::*;

    localparam int CNT_W  = $clog2(ROW_WORDS);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ICNT_W = $clog2(ROM_LATENCY + 1);
    localparam logic [ROM_LATENCY-1:0] EXIT_MASK = ROM_LATENCY'(1) << (ROM_LATENCY - 1);

    fetch_state_t            state;
    fetch_state_t            state_nxt;
    logic [SPRITE_SEL_W-1:0] sprite_q;
    logic [SPRITE_SEL_W-1:0] sel_hold;
    logic [WORD_ADDR_W-1:0]  base_q;
    logic [WORD_ADDR_W-1:0]  addr_hold;
    logic [WORD_ADDR_W-1:0]  issue_addr;
    logic [CNT_W-1:0]        cnt_q;
    logic [ROM_LATENCY-1:0]  pipe_vld;
    logic [ROM_LATENCY-1:0]  pipe_last;
    logic [ICNT_W-1:0]       inflight;
    logic [FCNT_W-1:0]       fifo_count;
    logic [WORD_W:0]         fifo_rdata;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    credit;
    logic                    issue;
    logic                    issue_last;
    logic                    accept;
    logic                    pipe_draining;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + ICNT_W'(pipe_vld[i]);
        end
    end

    assign credit     = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
    assign issue_addr = base_q + WORD_ADDR_W'(cnt_q);
    assign issue_last = (cnt_q == CNT_W'(ROW_WORDS - 1));
    // WAIT may leave once only the exiting token remains; its word lands in the FIFO on this edge.
    assign pipe_draining = ((pipe_vld & ~EXIT_MASK) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (req_valid_i) state_nxt = ISSUE;
                ISSUE:   if (credit && issue_last) state_nxt = WAIT;
                WAIT:    if (pipe_draining) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o      = (state == IDLE) && !abort_i;
        accept           = req_ready_o && req_valid_i;
        issue            = (state == ISSUE) && credit && !abort_i;
        rom_sprite_sel_o = issue ? sprite_q : sel_hold;
        rom_word_addr_o  = issue ? issue_addr : addr_hold;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sprite_q  <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            sel_hold  <= '0;
            addr_hold <= '0;
        end else begin
            if (accept) begin
                sprite_q <= req_sprite_i;
                base_q   <= WORD_ADDR_W'(req_row_i) << $clog2(ROW_WORDS);
                cnt_q    <= '0;
            end
            if (issue) begin
                sel_hold  <= sprite_q;
                addr_hold <= issue_addr;
                cnt_q     <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort_i) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
        end else begin
            pipe_vld  <= (pipe_vld << 1) | ROM_LATENCY'(issue);
            pipe_last <= (pipe_last << 1) | ROM_LATENCY'(issue && issue_last);
        end
    end

    assign fifo_push = pipe_vld[ROM_LATENCY-1];
    assign fifo_pop  = pix_valid_o && pix_ready_i;

    sprite_word_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort_i),
        .push  (fifo_push),
        .wdata ({pipe_last[ROM_LATENCY-1], rom_data_i}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign pix_valid_o = (fifo_count != '0);
    assign pix_data_o  = fifo_rdata[WORD_W-1:0];
    assign pix_last_o  = fifo_rdata[WORD_W];
    assign busy_o      = (state != IDLE) || pix_valid_o;

    no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && !fifo_pop && (fifo_count == FCNT_W'(FIFO_DEPTH))));
endmodule
